regfile_hs: RTL
===============

# regfile_hs

Parametrised, handshaked successor to the system register file: a DEPTH x DATA_WIDTH configuration/status bank with per-entry reset values, read-only protection, bit-masked writes, error reporting and a back-pressurable read response. It sits between the system controller (command side) and the datapath blocks (ALU operands, UART/parity config), which consume the first NUM_DIRECT registers through a flat direct-out bus.

## Interface
- DATA_WIDTH, 8, register width
- DEPTH, 16, number of registers
- ADDR, 4, address width; 2^ADDR >= DEPTH
- NUM_DIRECT, 4, registers exported on REG_OUT (1..DEPTH)
- RST_VAL, reg 2 = 0x81, reg 3 = 0x20, others 0, DEPTH*DATA_WIDTH reset image; entry i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- RO_MASK, 0, DEPTH bits; bit i set = register i is read-only

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-low
- WrEn  in  1  write request
- RdEn  in  1  read request
- Address  in  ADDR  register index
- WrData  in  DATA_WIDTH  write data
- WrMask  in  DATA_WIDTH  per-bit write enable
- Req_RDY  out  1  command accepted this cycle when high
- RdData  out  DATA_WIDTH  read data
- RdData_VLD  out  1  read response valid
- Rsp_RDY  in  1  consumer accepts response
- RdData_ERR  out  1  response carries an error
- Cmd_ERR  out  1  one-cycle pulse: command rejected
- ErrCode  out  2  cause of last RdData_ERR/Cmd_ERR (from package)
- REG_OUT  out  NUM_DIRECT*DATA_WIDTH  live contents of registers 0..NUM_DIRECT-1
- PAR_INJ  in  1  present only with REGFILE_PARITY_EN; inverts stored parity on a write

## Operation
- Command = WrEn or RdEn high while Req_RDY high; accepted at that rising edge.
- Req_RDY = !RdData_VLD || Rsp_RDY. Requests while low are ignored (caller holds them).
- Response FSM: IDLE (no response) and HOLD (RdData_VLD=1). IDLE->HOLD on accepted read (valid or errored). HOLD->IDLE on Rsp_RDY with no new read; HOLD->HOLD on Rsp_RDY with new accepted read (new data loaded). RdData/RdData_ERR/ErrCode stable throughout HOLD.
- Write: regArr[a] <= (regArr[a] & ~WrMask) | (WrData & WrMask). Writes never produce a response.
- WrEn && RdEn together: no access, Cmd_ERR pulse, ErrCode=COLL.
- Address >= DEPTH: write dropped with Cmd_ERR, ErrCode=ADDR; read returns RdData=0, RdData_ERR=1, ErrCode=ADDR.
- Write to RO_MASK register: dropped, Cmd_ERR, ErrCode=RO. Reads of RO registers are normal.
- REG_OUT updates the edge after a write; no bypass.
- Reset: regArr <= RST_VAL; RdData=0, RdData_VLD=0, RdData_ERR=0, Cmd_ERR=0, ErrCode=OK, state IDLE, so Req_RDY=1. Reset mid-HOLD discards the response.

## Timing
- Read latency 1: accepted at edge N, RdData_VLD high after edge N.
- Back-to-back reads with Rsp_RDY=1: one response per cycle.
- Write at edge N, read accepted at edge N+1 of same address returns the new value.
- Cmd_ERR high exactly one cycle after the offending edge.

## Configuration
- REGFILE_PARITY_EN defined: each entry stores an even-parity bit over its data, computed on reset and on every write (after masking); PAR_INJ=1 on a write stores the inverted bit. Read recomputes parity; mismatch gives RdData_ERR=1, ErrCode=PAR, data still returned.
- Undefined: no parity storage, no PAR_INJ port, ErrCode PAR never produced.

## Structure
- Package regfile_pkg: ErrCode enum (OK=0, ADDR=1, RO=2, PAR/COLL=3 disambiguated by Cmd_ERR vs RdData_ERR), FSM state typedef.
- Sub-module regfile_parity: combinational parity generate/check, DATA_WIDTH-parametrised; instantiated only under REGFILE_PARITY_EN.

## Test plan
- Reset -> REG_OUT = {0x20,0x81,0x00,0x00} (reg3..reg0), Req_RDY=1, all flags 0; read addr 2 -> RdData=0x81 next cycle.
- Write addr 5 data 0xFF mask 0x0F, then read 5 -> 0x0F; write 0xA0 mask 0xF0, read -> 0xAF.
- Read addr 1 with Rsp_RDY=0 for 3 cycles -> RdData_VLD held, Req_RDY=0, queued write ignored; Rsp_RDY=1 -> response retired, Req_RDY=1.
- RO_MASK bit 3 set, write addr 3 0x55 -> Cmd_ERR pulse, ErrCode=RO, read 3 still 0x20; WrEn&RdEn together -> ErrCode COLL, no change.
- DEPTH=12: read addr 14 -> RdData=0, RdData_ERR=1, ErrCode=ADDR.
- With REGFILE_PARITY_EN: write addr 4 0x3C with PAR_INJ=1, read 4 -> RdData=0x3C, RdData_ERR=1, ErrCode=PAR; rewrite without PAR_INJ clears it.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types for the handshaked register file: error codes and response FSM states.
// Parity support in the design is enabled by defining REGFILE_PARITY_EN.
package regfile_pkg;

  // PAR and COLL share code 3; Cmd_ERR vs RdData_ERR tells them apart.
  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_ADDR     = 2'd1,
    ERR_RO       = 2'd2,
    ERR_PAR_COLL = 2'd3
  } err_code_e;

  localparam err_code_e ERR_PAR  = ERR_PAR_COLL;
  localparam err_code_e ERR_COLL = ERR_PAR_COLL;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/regfile_parity.sv
// Even-parity generator over one register entry; used for write, read-check and reset image
// when REGFILE_PARITY_EN is defined.
module regfile_parity #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  par
);
  assign par = ^data;
endmodule

// File: rtl/regfile_hs.sv
// Handshaked DEPTH x DATA_WIDTH register bank with masked writes, RO protection and error codes.
// Define REGFILE_PARITY_EN to store/check per-entry even parity and expose PAR_INJ.
module regfile_hs
  import regfile_pkg::*;
#(
  parameter int                              DATA_WIDTH = 8,
  parameter int                              DEPTH      = 16,
  parameter int                              ADDR       = 4,
  parameter int                              NUM_DIRECT = 4,
  parameter logic [DEPTH*DATA_WIDTH-1:0]     RST_VAL    = (DEPTH*DATA_WIDTH)'(32'h2081_0000),
  parameter logic [DEPTH-1:0]                RO_MASK    = '0
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             WrEn,
  input  logic                             RdEn,
  input  logic [ADDR-1:0]                  Address,
  input  logic [DATA_WIDTH-1:0]            WrData,
  input  logic [DATA_WIDTH-1:0]            WrMask,
  output logic                             Req_RDY,
  output logic [DATA_WIDTH-1:0]            RdData,
  output logic                             RdData_VLD,
  input  logic                             Rsp_RDY,
  output logic                             RdData_ERR,
  output logic                             Cmd_ERR,
  output logic [1:0]                       ErrCode,
`ifdef REGFILE_PARITY_EN
  input  logic                             PAR_INJ,
`endif
  output logic [NUM_DIRECT*DATA_WIDTH-1:0] REG_OUT
);

  localparam logic [ADDR:0] DEPTH_L = (ADDR+1)'(DEPTH);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] reg_arr;
  rsp_state_e                       state;

  logic                  acc_wr, acc_rd, coll, addr_ok, ro_hit, wr_ok, par_bad;
  logic [ADDR-1:0]       idx;
  logic [DATA_WIDTH-1:0] cur, wr_new;

  // A new command can only land when the held response retires in the same edge.
  assign Req_RDY    = (state == ST_IDLE) || Rsp_RDY;
  assign RdData_VLD = (state == ST_HOLD);

  assign coll    = WrEn & RdEn & Req_RDY;
  assign acc_wr  = WrEn & ~RdEn & Req_RDY;
  assign acc_rd  = RdEn & ~WrEn & Req_RDY;
  assign addr_ok = {1'b0, Address} < DEPTH_L;
  assign idx     = addr_ok ? Address : '0;
  assign cur     = reg_arr[idx];
  assign ro_hit  = RO_MASK[idx];
  assign wr_new  = (cur & ~WrMask) | (WrData & WrMask);
  assign wr_ok   = acc_wr & addr_ok & ~ro_hit;

  for (genvar i = 0; i < NUM_DIRECT; i++) begin : g_direct
    assign REG_OUT[i*DATA_WIDTH +: DATA_WIDTH] = reg_arr[i];
  end

`ifdef REGFILE_PARITY_EN
  logic [DEPTH-1:0] par_arr, par_rst;
  logic             par_new, par_cur;

  regfile_parity #(.DATA_WIDTH(DATA_WIDTH)) u_par_wr (.data(wr_new), .par(par_new));
  regfile_parity #(.DATA_WIDTH(DATA_WIDTH)) u_par_rd (.data(cur),    .par(par_cur));

  for (genvar i = 0; i < DEPTH; i++) begin : g_par_rst
    regfile_parity #(.DATA_WIDTH(DATA_WIDTH)) u_par (
      .data(RST_VAL[i*DATA_WIDTH +: DATA_WIDTH]),
      .par (par_rst[i])
    );
  end

  assign par_bad = par_cur ^ par_arr[idx];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)       par_arr      <= par_rst;
    else if (wr_ok) par_arr[idx] <= par_new ^ PAR_INJ;
  end
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      reg_arr    <= RST_VAL;
      state      <= ST_IDLE;
      RdData     <= '0;
      RdData_ERR <= 1'b0;
      Cmd_ERR    <= 1'b0;
      ErrCode    <= ERR_OK;
    end else begin
      Cmd_ERR <= 1'b0;
      if (state == ST_HOLD && Rsp_RDY) state <= ST_IDLE;
      if (coll) begin
        Cmd_ERR <= 1'b1;
        ErrCode <= ERR_COLL;
      end else if (acc_wr) begin
        if (!addr_ok) begin
          Cmd_ERR <= 1'b1;
          ErrCode <= ERR_ADDR;
        end else if (ro_hit) begin
          Cmd_ERR <= 1'b1;
          ErrCode <= ERR_RO;
        end else begin
          reg_arr[idx] <= wr_new;
        end
      end else if (acc_rd) begin
        state <= ST_HOLD;
        if (!addr_ok) begin
          RdData     <= '0;
          RdData_ERR <= 1'b1;
          ErrCode    <= ERR_ADDR;
        end else begin
          // Data is still returned on a parity mismatch.
          RdData     <= cur;
          RdData_ERR <= par_bad;
          ErrCode    <= par_bad ? ERR_PAR : ERR_OK;
        end
      end
    end
  end

endmodule
